// File: rtl/register_file.sv
// rtl/register_file.sv - ARM register file: R0-R14 storage, R15 passthrough, registered bypassed reads, load-use scoreboard
module register_file #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] RA1,
   input  logic [ADDR_W-1:0] RA2,
   output logic [DATA_W-1:0] RD1,
   output logic [DATA_W-1:0] RD2,
   input  logic              WE3,
   input  logic [ADDR_W-1:0] WA3,
   input  logic [DATA_W-1:0] WD3,
   input  logic [DATA_W-1:0] R15,
   input  logic              pend_set,
   input  logic [ADDR_W-1:0] pend_addr,
   output logic              stall
);
   localparam int NREG = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] PC_ADDR = '1;

   // The PC slot is declared but never written, so it reads as constant zero and is never selected.
   logic [DATA_W-1:0] regs [NREG];
   logic [NREG-1:0]   pend;
   logic              wr_ok;
   logic              ld_ok;
   logic              hazard1;
   logic              hazard2;
   logic [DATA_W-1:0] src1;
   logic [DATA_W-1:0] src2;

   assign wr_ok = WE3 && (WA3 != PC_ADDR);
   assign ld_ok = pend_set && (pend_addr != PC_ADDR);

   always_comb begin
      src1 = regs[RA1];
      if (RA1 == PC_ADDR)
         src1 = R15;
      else if (WE3 && (WA3 == RA1))
         src1 = WD3;

      src2 = regs[RA2];
      if (RA2 == PC_ADDR)
         src2 = R15;
      else if (WE3 && (WA3 == RA2))
         src2 = WD3;

      // A write-back landing this cycle satisfies the outstanding load.
      hazard1 = pend[RA1] && (RA1 != PC_ADDR) && !(WE3 && (WA3 == RA1));
      hazard2 = pend[RA2] && (RA2 != PC_ADDR) && !(WE3 && (WA3 == RA2));
   end

   assign stall = rd_en && (hazard1 || hazard2);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= '0;
      end else if (wr_ok) begin
         regs[WA3] <= WD3;
      end
   end

   // Set is applied after clear so a new load to the same register wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend <= '0;
      end else begin
         if (wr_ok)
            pend[WA3] <= 1'b0;
         if (ld_ok)
            pend[pend_addr] <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         RD1 <= '0;
         RD2 <= '0;
      end else if (rd_en && !stall) begin
         RD1 <= src1;
         RD2 <= src2;
      end
   end
endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed vector table plus randomized model check for register_file
module tb_register_file;
   logic        clk = 1'b0;
   logic        reset;
   logic        rd_en;
   logic [3:0]  RA1, RA2, WA3, pend_addr;
   logic [31:0] RD1, RD2, WD3, R15;
   logic        WE3, pend_set, stall;

   int checks = 0;
   int errors = 0;

   register_file #(.DATA_W(32), .ADDR_W(4)) dut (
      .clk(clk), .reset(reset), .rd_en(rd_en), .RA1(RA1), .RA2(RA2),
      .RD1(RD1), .RD2(RD2), .WE3(WE3), .WA3(WA3), .WD3(WD3), .R15(R15),
      .pend_set(pend_set), .pend_addr(pend_addr), .stall(stall)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rd_en;
      logic [3:0]  ra1;
      logic [3:0]  ra2;
      logic        we;
      logic [3:0]  wa;
      logic [31:0] wd;
      logic        ps;
      logic [3:0]  pa;
      logic        e_stall;
      logic [31:0] e_rd1;
      logic [31:0] e_rd2;
   } vec_t;

   vec_t tbl[21];

   // Reference model: architectural registers, outstanding-load set, captured read values.
   logic [31:0] m_reg[16];
   bit          m_pend[16];
   logic [31:0] m_rd1, m_rd2;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] m_src(input logic [3:0] a);
      if (a == 4'd15) return R15;
      if (WE3 && WA3 == a) return WD3;
      return m_reg[a];
   endfunction

   function automatic bit m_waiting(input logic [3:0] a);
      return a != 4'd15 && m_pend[a] && !(WE3 && WA3 == a);
   endfunction

   function automatic bit m_stall();
      return rd_en && (m_waiting(RA1) || m_waiting(RA2));
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 16; i++) begin
         m_reg[i] = '0;
         m_pend[i] = 0;
      end
      m_rd1 = '0;
      m_rd2 = '0;
   endtask

   // Model state advances at the falling edge, using the inputs that the next rising edge will see.
   task automatic m_advance();
      if (rd_en && !m_stall()) begin
         m_rd1 = m_src(RA1);
         m_rd2 = m_src(RA2);
      end
      if (WE3 && WA3 != 4'd15) begin
         m_reg[WA3] = WD3;
         m_pend[WA3] = 0;
      end
      if (pend_set && pend_addr != 4'd15)
         m_pend[pend_addr] = 1;
   endtask

   task automatic drive(input vec_t v);
      rd_en = v.rd_en; RA1 = v.ra1; RA2 = v.ra2;
      WE3 = v.we; WA3 = v.wa; WD3 = v.wd;
      pend_set = v.ps; pend_addr = v.pa;
   endtask

   task automatic idle();
      rd_en = 0; RA1 = 0; RA2 = 0; WE3 = 0; WA3 = 0; WD3 = 0;
      pend_set = 0; pend_addr = 0;
   endtask

   initial begin
      R15 = 32'h0000_0108;
      m_reset();

      // row: rd_en ra1 ra2 we wa wd ps pa | stall rd1 rd2
      tbl[0]  = '{1'b1, 4'd3,  4'd3,  1'b0, 4'd0,  32'h0,         1'b0, 4'd0,  1'b0, 32'h0,         32'h0};
      tbl[1]  = '{1'b0, 4'd0,  4'd0,  1'b1, 4'd5,  32'h1234_5678, 1'b0, 4'd0,  1'b0, 32'h0,         32'h0};
      tbl[2]  = '{1'b0, 4'd0,  4'd0,  1'b0, 4'd0,  32'h0,         1'b0, 4'd0,  1'b0, 32'h0,         32'h0};
      tbl[3]  = '{1'b1, 4'd5,  4'd0,  1'b0, 4'd0,  32'h0,         1'b0, 4'd0,  1'b0, 32'h1234_5678, 32'h0};
      tbl[4]  = '{1'b1, 4'd5,  4'd7,  1'b1, 4'd7,  32'hA5A5_A5A5, 1'b0, 4'd0,  1'b0, 32'h1234_5678, 32'hA5A5_A5A5};
      tbl[5]  = '{1'b0, 4'd0,  4'd0,  1'b1, 4'd15, 32'hDEAD_BEEF, 1'b0, 4'd0,  1'b0, 32'h1234_5678, 32'hA5A5_A5A5};
      tbl[6]  = '{1'b1, 4'd15, 4'd7,  1'b0, 4'd0,  32'h0,         1'b0, 4'd0,  1'b0, 32'h0000_0108, 32'hA5A5_A5A5};
      tbl[7]  = '{1'b0, 4'd0,  4'd0,  1'b0, 4'd0,  32'h0,         1'b1, 4'd2,  1'b0, 32'h0000_0108, 32'hA5A5_A5A5};
      tbl[8]  = '{1'b1, 4'd2,  4'd7,  1'b0, 4'd0,  32'h0,         1'b0, 4'd0,  1'b1, 32'h0000_0108, 32'hA5A5_A5A5};
      tbl[9]  = '{1'b1, 4'd2,  4'd7,  1'b0, 4'd0,  32'h0,         1'b0, 4'd0,  1'b1, 32'h0000_0108, 32'hA5A5_A5A5};
      tbl[10] = '{1'b1, 4'd2,  4'd7,  1'b1, 4'd2,  32'h55,        1'b0, 4'd0,  1'b0, 32'h55,        32'hA5A5_A5A5};
      tbl[11] = '{1'b0, 4'd0,  4'd0,  1'b0, 4'd0,  32'h0,         1'b1, 4'd4,  1'b0, 32'h55,        32'hA5A5_A5A5};
      tbl[12] = '{1'b0, 4'd0,  4'd0,  1'b1, 4'd4,  32'h44,        1'b1, 4'd4,  1'b0, 32'h55,        32'hA5A5_A5A5};
      tbl[13] = '{1'b1, 4'd4,  4'd4,  1'b0, 4'd0,  32'h0,         1'b0, 4'd0,  1'b1, 32'h55,        32'hA5A5_A5A5};
      tbl[14] = '{1'b1, 4'd4,  4'd4,  1'b1, 4'd4,  32'h99,        1'b0, 4'd0,  1'b0, 32'h99,        32'h99};
      tbl[15] = '{1'b1, 4'd4,  4'd2,  1'b0, 4'd0,  32'h0,         1'b0, 4'd0,  1'b0, 32'h99,        32'h55};
      tbl[16] = '{1'b0, 4'd0,  4'd0,  1'b0, 4'd0,  32'h0,         1'b1, 4'd9,  1'b0, 32'h99,        32'h55};
      tbl[17] = '{1'b1, 4'd0,  4'd9,  1'b0, 4'd0,  32'h0,         1'b0, 4'd0,  1'b1, 32'h99,        32'h55};
      tbl[18] = '{1'b1, 4'd0,  4'd9,  1'b1, 4'd9,  32'h9,         1'b0, 4'd0,  1'b0, 32'h0,         32'h9};
      tbl[19] = '{1'b0, 4'd0,  4'd0,  1'b0, 4'd0,  32'h0,         1'b1, 4'd15, 1'b0, 32'h0,         32'h9};
      tbl[20] = '{1'b1, 4'd15, 4'd15, 1'b0, 4'd0,  32'h0,         1'b0, 4'd0,  1'b0, 32'h0000_0108, 32'h0000_0108};

      // Reset held while a write and a load issue are presented.
      reset = 1'b1;
      idle();
      rd_en = 1; RA1 = 3; RA2 = 3; WE3 = 1; WA3 = 3; WD3 = 32'hFFFF_FFFF;
      pend_set = 1; pend_addr = 3;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_rd1", RD1, 32'h0);
      chk("reset_rd2", RD2, 32'h0);
      chk("reset_stall", {31'b0, stall}, 32'h0);
      reset = 1'b0;
      idle();

      for (int i = 0; i < 21; i++) begin
         drive(tbl[i]);
         @(negedge clk);
         chk($sformatf("vec%0d_stall", i), {31'b0, stall}, {31'b0, tbl[i].e_stall});
         m_advance();
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_rd1", i), RD1, tbl[i].e_rd1);
         chk($sformatf("vec%0d_rd2", i), RD2, tbl[i].e_rd2);
      end

      for (int i = 0; i < 400; i++) begin
         rd_en = ($urandom_range(0, 3) != 0);
         RA1 = 4'($urandom_range(0, 15));
         RA2 = ($urandom_range(0, 4) == 0) ? RA1 : 4'($urandom_range(0, 15));
         WE3 = ($urandom_range(0, 1) == 1);
         WA3 = ($urandom_range(0, 2) == 0) ? RA1 : 4'($urandom_range(0, 15));
         WD3 = $urandom;
         R15 = $urandom;
         pend_set = ($urandom_range(0, 3) == 0);
         pend_addr = ($urandom_range(0, 3) == 0) ? WA3 : 4'($urandom_range(0, 15));
         @(negedge clk);
         chk("rand_stall", {31'b0, stall}, {31'b0, m_stall()});
         m_advance();
         @(posedge clk);
         #1;
         chk("rand_rd1", RD1, m_rd1);
         chk("rand_rd2", RD2, m_rd2);
      end

      // Mid-run asynchronous reset discards an outstanding load.
      R15 = 32'h0000_0108;
      idle();
      WE3 = 1; WA3 = 6; WD3 = 32'h6666_6666;
      @(posedge clk);
      #1;
      idle();
      pend_set = 1; pend_addr = 6;
      @(posedge clk);
      #1;
      idle();
      rd_en = 1; RA1 = 6; RA2 = 1;
      #2;
      chk("pre_reset_stall", {31'b0, stall}, 32'h1);
      reset = 1'b1;
      #1;
      chk("async_reset_stall", {31'b0, stall}, 32'h0);
      chk("async_reset_rd1", RD1, 32'h0);
      chk("async_reset_rd2", RD2, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      m_reset();
      @(posedge clk);
      #1;
      chk("post_reset_r6", RD1, 32'h0);
      chk("post_reset_stall", {31'b0, stall}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/register_file.md
# register_file

ARM core register file: the responder to the RA1/RA2 read-address selection made in decode, plus the write-back target for WA3/WD3. It holds R0–R14, returns the externally supplied PC+8 for R15, and registers both read ports into the decode/execute boundary with same-cycle write bypass. A per-register pending-load scoreboard raises `stall` when decode reads a register whose load has not yet written back.

## Interface
Parameters:
- DATA_W, 32, register and data width
- ADDR_W, 4, register address width (16 architectural registers)

Ports:
- clk  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- rd_en  input  1  decode issues a read this cycle
- RA1  input  ADDR_W  read address, port 1 (Rn)
- RA2  input  ADDR_W  read address, port 2 (Rm or Rd, already muxed upstream)
- RD1  output  DATA_W  registered read data, port 1
- RD2  output  DATA_W  registered read data, port 2
- WE3  input  1  write-back enable
- WA3  input  ADDR_W  write-back address
- WD3  input  DATA_W  write-back data
- R15  input  DATA_W  current PC+8, returned for reads of register 15
- pend_set  input  1  a load targeting pend_addr issued this cycle
- pend_addr  input  ADDR_W  destination of the issuing load
- stall  output  1  combinational; decode must hold its instruction

## Operation
- Storage: 15 × DATA_W registers R0–R14; R15 has no storage.
- Write: on a rising edge with WE3=1 and WA3≠15, R[WA3]←WD3. Writes with WA3=15 are ignored; PC writes are handled by fetch.
- Read source per port x, priority order:
  - RAx=15: R15 input.
  - WE3=1 and WA3=RAx (≠15): WD3 (bypass).
  - Otherwise: R[RAx].
- Read capture: on a rising edge with rd_en=1 and stall=0, RD1/RD2 ← the selected sources. Otherwise RD1/RD2 hold.
- Scoreboard: pend[14:0], one bit per register.
  - Rising edge with WE3=1 and WA3≠15: clear pend[WA3].
  - Rising edge with pend_set=1 and pend_addr≠15: set pend[pend_addr].
  - Set and clear on the same address in the same cycle: set wins, because a new load is outstanding.
  - pend_set to 15 is ignored.
- hazard_x = pend[RAx] & (RAx≠15) & ~(WE3 & WA3==RAx).
- stall = rd_en & (hazard_1 | hazard_2). stall is purely combinational from current inputs and pend.
- Duplicate addresses: RA1=RA2 is legal, and both ports return the same value.
- Reset (asynchronous, immediate):
  - R0–R14 = 0, RD1 = 0, RD2 = 0, pend = 0.
  - stall therefore reads 0 while reset is held.
  - Reset asserted mid-operation discards all pending state. No write occurs on the edge coincident with reset.

## Timing
- Read latency: 1 cycle. Address presented in cycle N appears on RD1/RD2 after the rising edge ending cycle N.
- Write-to-read: a write in cycle N is visible to a read in cycle N through the bypass, and to reads in cycle N+1 onward from storage.
- Load-use: pend_set in cycle N makes stall assertable from cycle N+1. stall deasserts combinationally in the cycle WE3 writes that register, so the read completes in that same cycle.
- While stall=1, RD1/RD2 hold their previous values. Upstream must keep RA1/RA2/rd_en stable.
- No internal multi-cycle state machine; the scoreboard is the only cross-cycle control state.

## Test plan
- Reset: hold reset with WE3=1, WA3=3, WD3=0xFFFF_FFFF and pend_set=1 → RD1=RD2=0, stall=0. After release, reading R3 returns 0.
- Write then read: write R5=0x1234_5678 in cycle 0; read RA1=5 with rd_en in cycle 2 → RD1=0x1234_5678 after that edge.
- Bypass: same cycle WE3=1, WA3=7, WD3=0xA5A5_A5A5, RA2=7, rd_en=1 → RD2=0xA5A5_A5A5 next cycle.
- R15 behaviour: R15=0x0000_0108, write WA3=15 with WD3=0xDEAD_BEEF, then read RA1=15 → RD1=0x0000_0108.
- Load-use stall: pend_set, pend_addr=2 in cycle 0; RA1=2 with rd_en in cycles 1–3 → stall=1 and RD1 held in cycles 1–2. WE3, WA3=2, WD3=0x55 in cycle 3 → stall=0 in cycle 3 and RD1=0x55 after that edge.
- Set/clear collision: pend[4]=1; in one cycle apply WE3, WA3=4 together with pend_set, pend_addr=4. Reading R4 in the next cycle → stall=1. A later write to R4 clears it.
